// File: rtl/elevator_gen.sv
// Elevator band generator and game-flow controller: scrolls three gapped bands,
// re-randomises a gap on wrap, keeps score, ramps speed and ends the game on collision.
module elevator_gen #(
    parameter int          SPACING   = 160,
    parameter int          THICK     = 8,
    parameter int          GAP_W     = 48,
    parameter int          GAP_BASE  = 64,
    parameter int          SPD_INIT  = 1,
    parameter int          SPD_MAX   = 4,
    parameter logic [8:0]  LFSR_SEED = 9'h1A5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       hit,
    input  logic       in_gap,
    input  logic       inc_score,
    output logic [9:0] elev1Top,
    output logic [9:0] elev1Bot,
    output logic [9:0] elev1L,
    output logic [9:0] elev1R,
    output logic [9:0] elev2Top,
    output logic [9:0] elev2Bot,
    output logic [9:0] elev2L,
    output logic [9:0] elev2R,
    output logic [9:0] elev3Top,
    output logic [9:0] elev3Bot,
    output logic [9:0] elev3L,
    output logic [9:0] elev3R,
    output logic [7:0] score,
    output logic [2:0] speed,
    output logic       running,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [9:0] WRAP_C  = 10'(3 * SPACING);
    localparam logic [9:0] THICK_C = 10'(THICK);
    localparam logic [9:0] GAPW_C  = 10'(GAP_W);
    localparam logic [9:0] GBASE_C = 10'(GAP_BASE);
    localparam logic [2:0] SINIT_C = 3'(SPD_INIT);
    localparam logic [2:0] SMAX_C  = 3'(SPD_MAX);

    state_t     state_q, state_d;
    logic [9:0] bot_q [3];
    logic [9:0] bot_d [3];
    logic [9:0] top_q [3];
    logic [9:0] top_d [3];
    logic [9:0] l_q   [3];
    logic [9:0] l_d   [3];
    logic [9:0] r_q   [3];
    logic [9:0] r_d   [3];
    logic [7:0] score_q, score_d;
    logic [2:0] speed_q, speed_d;
    logic [8:0] lfsr_q, lfsr_d;
    logic [8:0] lfsr_v;
    logic       inc_q;
    logic       collide;
    logic       inc_edge;

    // x^9 + x^5 + 1, Fibonacci form
    function automatic logic [8:0] lfsr_next(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    function automatic logic [9:0] init_bot(input int n);
        return 10'((n + 1) * SPACING);
    endfunction

    function automatic logic [9:0] init_l(input int n);
        return 10'(GAP_BASE + n * 128);
    endfunction

    assign collide  = hit & ~in_gap;
    assign inc_edge = inc_score & ~inc_q;

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        speed_d = speed_q;
        lfsr_d  = lfsr_q;
        lfsr_v  = lfsr_q;
        for (int i = 0; i < 3; i++) begin
            bot_d[i] = bot_q[i];
            top_d[i] = top_q[i];
            l_d[i]   = l_q[i];
            r_d[i]   = r_q[i];
        end

        case (state_q)
            IDLE: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (start) state_d = PLAY;
            end
            PLAY: begin
                if (collide) begin
                    state_d = OVER;
                end else begin
                    if (frame_tick) begin
                        // Bands wrapping in the same frame draw successive lfsr states in band order
                        for (int i = 0; i < 3; i++) begin
                            if (bot_q[i] >= {7'd0, speed_q}) begin
                                bot_d[i] = bot_q[i] - {7'd0, speed_q};
                            end else begin
                                bot_d[i] = bot_q[i] + WRAP_C - {7'd0, speed_q};
                                l_d[i]   = GBASE_C + {1'b0, lfsr_v};
                                lfsr_v   = lfsr_next(lfsr_v);
                            end
                            top_d[i] = bot_d[i] + THICK_C;
                            r_d[i]   = l_d[i] + GAPW_C;
                        end
                        lfsr_d = lfsr_v;
                    end
                    if (inc_edge && (score_q != 8'hFF)) begin
                        score_d = score_q + 8'd1;
                        if ((score_d[2:0] == 3'd0) && (speed_q < SMAX_C))
                            speed_d = speed_q + 3'd1;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_d = PLAY;
                    score_d = 8'd0;
                    speed_d = SINIT_C;
                    for (int i = 0; i < 3; i++) begin
                        bot_d[i] = init_bot(i);
                        top_d[i] = init_bot(i) + THICK_C;
                        l_d[i]   = init_l(i);
                        r_d[i]   = init_l(i) + GAPW_C;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            score_q <= 8'd0;
            speed_q <= SINIT_C;
            lfsr_q  <= LFSR_SEED;
            inc_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                bot_q[i] <= init_bot(i);
                top_q[i] <= init_bot(i) + THICK_C;
                l_q[i]   <= init_l(i);
                r_q[i]   <= init_l(i) + GAPW_C;
            end
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            speed_q <= speed_d;
            lfsr_q  <= lfsr_d;
            inc_q   <= inc_score;
            for (int i = 0; i < 3; i++) begin
                bot_q[i] <= bot_d[i];
                top_q[i] <= top_d[i];
                l_q[i]   <= l_d[i];
                r_q[i]   <= r_d[i];
            end
        end
    end

    assign elev1Bot  = bot_q[0];
    assign elev1Top  = top_q[0];
    assign elev1L    = l_q[0];
    assign elev1R    = r_q[0];
    assign elev2Bot  = bot_q[1];
    assign elev2Top  = top_q[1];
    assign elev2L    = l_q[1];
    assign elev2R    = r_q[1];
    assign elev3Bot  = bot_q[2];
    assign elev3Top  = top_q[2];
    assign elev3L    = l_q[2];
    assign elev3R    = r_q[2];
    assign score     = score_q;
    assign speed     = speed_q;
    assign running   = (state_q == PLAY);
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_elevator_gen.sv
// Directed bench for elevator_gen: reset, idle freeze, scrolling and wrap,
// scoring and speed ramp, collision priority, restart and mid-game reset.
module tb_elevator_gen;

    logic       clk = 1'b0;
    logic       rst_n, frame_tick, start, hit, in_gap, inc_score;
    logic [9:0] e1t, e1b, e1l, e1r, e2t, e2b, e2l, e2r, e3t, e3b, e3l, e3r;
    logic [7:0] score;
    logic [2:0] speed;
    logic       running, game_over;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] m_lfsr = 9'h1A5;
    bit         m_idle = 1'b1;
    int         exp_l;

    always #5 clk = ~clk;

    elevator_gen dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start),
        .hit(hit), .in_gap(in_gap), .inc_score(inc_score),
        .elev1Top(e1t), .elev1Bot(e1b), .elev1L(e1l), .elev1R(e1r),
        .elev2Top(e2t), .elev2Bot(e2b), .elev2L(e2l), .elev2R(e2r),
        .elev3Top(e3t), .elev3Bot(e3b), .elev3L(e3l), .elev3R(e3r),
        .score(score), .speed(speed), .running(running), .game_over(game_over)
    );

    function automatic logic [8:0] lfsr_next(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; the reference lfsr follows the spec's free-run-in-IDLE rule
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            m_lfsr = 9'h1A5;
            m_idle = 1'b1;
        end else if (m_idle) begin
            m_lfsr = lfsr_next(m_lfsr);
            if (start) m_idle = 1'b0;
        end
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_inc(input int w);
        inc_score = 1'b1;
        repeat (w) step();
        inc_score = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0;
        hit = 1'b0; in_gap = 1'b0; inc_score = 1'b0;

        // T1 reset values
        step(); step();
        check("rst_b1", e1b, 160); check("rst_b2", e2b, 320); check("rst_b3", e3b, 480);
        check("rst_t1", e1t, 168); check("rst_t2", e2t, 328); check("rst_t3", e3t, 488);
        check("rst_l1", e1l, 64);  check("rst_l2", e2l, 192); check("rst_l3", e3l, 320);
        check("rst_r1", e1r, 112); check("rst_r2", e2r, 240); check("rst_r3", e3r, 368);
        check("rst_score", score, 0); check("rst_speed", speed, 1);
        check("rst_run", running, 0); check("rst_over", game_over, 0);
        rst_n = 1'b1;

        // T2 bands frozen in IDLE, then first move after start
        repeat (5) tick();
        check("idle_b1", e1b, 160); check("idle_b3", e3b, 480); check("idle_run", running, 0);
        repeat (3) step();
        start = 1'b1; step(); start = 1'b0;
        check("start_run", running, 1);
        tick();
        check("mv_b1", e1b, 159); check("mv_b2", e2b, 319); check("mv_b3", e3b, 479);
        check("mv_t1", e1t, 167);

        // T3 band 1 wraps and draws a new gap from the lfsr
        repeat (159) tick();
        check("pre_wrap_b1", e1b, 0);
        check("pre_wrap_l1", e1l, 64);
        tick();
        exp_l = 64 + int'(m_lfsr);
        m_lfsr = lfsr_next(m_lfsr);
        check("wrap_b1", e1b, 479); check("wrap_t1", e1t, 487);
        check("wrap_l1", e1l, exp_l); check("wrap_r1", e1r, exp_l + 48);
        check("wrap_b2", e2b, 159); check("wrap_b3", e3b, 319);
        check("wrap_l2", e2l, 192); check("wrap_l3", e3l, 320);

        // T4 score edges and speed ramp
        repeat (8) pulse_inc(3);
        check("sc8", score, 8); check("spd8", speed, 2);
        inc_score = 1'b1; repeat (10) step(); inc_score = 1'b0; step();
        check("sc_level", score, 9); check("spd9", speed, 2);
        repeat (7) pulse_inc(3);
        check("sc16", score, 16); check("spd16", speed, 3);
        repeat (8) pulse_inc(3);
        check("sc24", score, 24); check("spd24", speed, 4);
        repeat (8) pulse_inc(3);
        check("sc32", score, 32); check("spd32_cap", speed, 4);
        check("noscroll_b1", e1b, 479);

        // T5 hit inside a gap keeps playing; hit outside a gap ends the game
        hit = 1'b1; in_gap = 1'b1; frame_tick = 1'b1;
        step();
        hit = 1'b0; in_gap = 1'b0; frame_tick = 1'b0;
        check("gap_run", running, 1); check("gap_b1", e1b, 475); check("gap_b2", e2b, 155);
        hit = 1'b1; in_gap = 1'b0; frame_tick = 1'b1; inc_score = 1'b1;
        step();
        hit = 1'b0; frame_tick = 1'b0; inc_score = 1'b0;
        check("col_over", game_over, 1); check("col_run", running, 0);
        check("col_b1", e1b, 475); check("col_score", score, 32);
        tick();
        check("over_frz_b1", e1b, 475); check("over_frz_spd", speed, 4);

        // T6 restart from OVER, lfsr carries on, then reset mid-game
        start = 1'b1; step(); start = 1'b0;
        check("rs_run", running, 1); check("rs_over", game_over, 0);
        check("rs_b1", e1b, 160); check("rs_t3", e3t, 488); check("rs_l1", e1l, 64);
        check("rs_score", score, 0); check("rs_speed", speed, 1);
        repeat (161) tick();
        exp_l = 64 + int'(m_lfsr);
        m_lfsr = lfsr_next(m_lfsr);
        check("rs_wrap_b1", e1b, 479); check("rs_wrap_l1", e1l, exp_l);
        tick();
        rst_n = 1'b0; frame_tick = 1'b1; start = 1'b1; inc_score = 1'b1;
        step();
        rst_n = 1'b1; frame_tick = 1'b0; start = 1'b0; inc_score = 1'b0;
        check("mrst_run", running, 0); check("mrst_b1", e1b, 160);
        check("mrst_l1", e1l, 64); check("mrst_score", score, 0); check("mrst_speed", speed, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
